vga_timing_counter: RTL and testbench
=====================================

// Module: vga_timing_counter
// PURPOSE
//  Generates horizontal and vertical scan counts for 640x480@60 VGA timing from the system clock.
//  Feeds the sync comparators: h_count drives the HS compare (< H_SYNC), v_count the VS compare (< V_SYNC).
//  Also produces pixel-enable, active-video, pixel coordinates and line/frame strobes for the renderer.
//  Line/frame origin is count 0 = first sync cycle; sync, back porch, active and front porch follow in order.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  H_ACTIVE  640  horizontal visible pixels
//  H_FP      16   horizontal front porch, pixels (H_TOTAL = 800)
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch, lines (V_TOTAL = 525)
// PORTS
//  clk         in   1   system clock
//  resetn      in   1   asynchronous active-low reset
//  en          in   1   run enable; low freezes all counters
//  pix_en      out  1   one-clk pixel tick, asserted once every CLK_DIV enabled clocks
//  h_count     out  10  horizontal position 0..H_TOTAL-1
//  v_count     out  10  vertical position 0..V_TOTAL-1
//  active      out  1   h_count and v_count both inside the visible window
//  x           out  10  h_count-(H_SYNC+H_BP) when active, else 0
//  y           out  10  v_count-(V_SYNC+V_BP) when active, else 0
//  line_end    out  1   pix_en & (h_count==H_TOTAL-1)
//  frame_end   out  1   line_end & (v_count==V_TOTAL-1)
// BEHAVIOUR
//  Reset (async assert, sync release): div=0, h_count=0, v_count=0, active=0, x=y=0; all strobes 0.
//  Divider: div counts 0..CLK_DIV-1 on each clk with en=1 and wraps to 0.
//   pix_en = en & (div==CLK_DIV-1), decoded from the registered div with no extra register stage.
//   CLK_DIV=1: pix_en = en.
//  First pix_en falls on the CLK_DIV-th enabled clock after reset release.
//  Horizontal: h_count advances at the edge that ends a pix_en cycle; it wraps H_TOTAL-1 -> 0.
//  Vertical: v_count advances only at a line_end edge; it wraps V_TOTAL-1 -> 0 on the same edge as h.
//   A simultaneous h/v wrap (frame_end) takes both counters to 0,0 in one edge.
//  active, x and y are registered from the next-state counts, so they align with h_count/v_count every cycle.
//   active = (H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE) & (V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACTIVE).
//  line_end and frame_end are combinational from pix_en and the registered counts; each is 1 clk wide.
//  en=0: div, h_count and v_count hold; pix_en=line_end=frame_end=0; active/x/y hold.
//   Re-asserting en resumes exactly where it stopped; no tick is lost or duplicated.
//  Reset mid-line or mid-frame: all state returns to its reset values immediately; no partial-line recovery.
//  All counts are 10-bit unsigned. Parameter sums must be <= 1024; an elaboration check errors on overflow.
//  Counters never leave their legal ranges, so no out-of-range state exists.
// STRUCTURE
//  vga_timing_pkg (include header): default timing localparams, H_TOTAL/V_TOTAL, active start/end constants.
//  Sub-module vga_axis_counter (param TOTAL): count register with inc/wrap, outputs count and wrap (= inc & at max).
//   Instanced once for h (inc = pix_en) and once for v (inc = h wrap).
//  Divider, active window decode and x/y subtraction live in the top level.
// TESTING
//  Reset release with en=1, CLK_DIV=4 -> pix_en high on clocks 3,7,11,...; h_count 0->1 after clock 3.
//  Run 800 pixel ticks -> line_end exactly once at h=799; h wraps to 0 and v 0->1 on the same edge.
//  Full frame of 420000 ticks -> frame_end once; h,v go 799,524 -> 0,0 on one edge.
//   Check active count = 307200.
//  Scan h=143/144/783/784 at v=35 -> active 0/1/1/0; x=0 at h=144; x=639 at h=783.
//   Check active=0 for all h at v=34 and v=515.
//  Drop en for 7 clocks mid-line at h=200 -> counts and div hold; next pix_en follows the remaining div cycles.
//  Assert resetn=0 at h=500,v=300 -> all outputs 0 asynchronously; restart matches the first scenario.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : shared count type and default 640x480@60 timing constants
// Revision      : 1.0
// ============================================================================
package vga_timing_pkg;

   localparam int CNT_W     = 10;
   localparam int CNT_LIMIT = 1 << CNT_W;

   typedef logic [CNT_W-1:0] count_t;

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;

   localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

   // Compared one bit wider so a window ending exactly at CNT_LIMIT still works.
   function automatic logic in_window(input count_t pos, input int start, input int stop);
      return ({1'b0, pos} >= (CNT_W+1)'(start)) && ({1'b0, pos} < (CNT_W+1)'(stop));
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// vga_axis_counter : one scan axis; advances on inc and wraps TOTAL-1 -> 0
// Revision         : 1.0
// ============================================================================
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL = DEF_H_TOTAL
) (
   input  logic   clk,
   input  logic   resetn,
   input  logic   inc,
   output count_t count,
   output count_t count_next,
   output logic   wrap
);

   localparam count_t MAX_COUNT = count_t'(TOTAL - 1);

   count_t count_q;
   count_t count_d;

   always_comb begin
      wrap    = inc && (count_q == MAX_COUNT);
      count_d = count_q;
      if (inc) begin
         count_d = wrap ? '0 : count_q + count_t'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count      = count_q;
   assign count_next = count_d;

endmodule
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// ============================================================================
// vga_timing_counter : pixel divider, h/v scan counters, visible-window decode
// Revision           : 1.0
// ============================================================================
module vga_timing_counter
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   output logic             pix_en,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic             active,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_end,
   output logic             frame_end
);

   localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_ACT_START = H_SYNC + H_BP;
   localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
   localparam int V_ACT_START = V_SYNC + V_BP;
   localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

   if (CLK_DIV < 1) begin : g_chk_div
      $error("vga_timing_counter: CLK_DIV must be >= 1");
   end
   if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_chk_total
      $error("vga_timing_counter: timing totals exceed 10-bit count range");
   end

   // pix_en is decoded straight from the divider register so it lines up with div.
   if (CLK_DIV == 1) begin : g_div_bypass
      assign pix_en = en;
   end else begin : g_div
      localparam int               DIV_W   = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_q;
      logic [DIV_W-1:0] div_d;

      always_comb begin
         div_d = div_q;
         if (en) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
         end
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            div_q <= '0;
         end else begin
            div_q <= div_d;
         end
      end

      assign pix_en = en && (div_q == DIV_MAX);
   end

   logic   h_wrap;
   logic   v_wrap;
   count_t h_next;
   count_t v_next;

   vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
      .clk        (clk),
      .resetn     (resetn),
      .inc        (pix_en),
      .count      (h_count),
      .count_next (h_next),
      .wrap       (h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
      .clk        (clk),
      .resetn     (resetn),
      .inc        (h_wrap),
      .count      (v_count),
      .count_next (v_next),
      .wrap       (v_wrap)
   );

   assign line_end  = h_wrap;
   assign frame_end = v_wrap;

   // Decoding the next-state counts keeps active/x/y cycle-aligned with h/v.
   logic   active_q;
   logic   active_d;
   count_t x_q;
   count_t x_d;
   count_t y_q;
   count_t y_d;

   always_comb begin
      active_d = in_window(h_next, H_ACT_START, H_ACT_END) &&
                 in_window(v_next, V_ACT_START, V_ACT_END);
      x_d = '0;
      y_d = '0;
      if (active_d) begin
         x_d = h_next - count_t'(H_ACT_START);
         y_d = v_next - count_t'(V_ACT_START);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         active_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
      end
   end

   assign active = active_q;
   assign x      = x_q;
   assign y      = y_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_counter.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_counter : random/directed checks against an arithmetic model
// Revision              : 1.0
// ============================================================================
module tb_vga_timing_counter;

   typedef struct packed {
      logic       pix_en;
      logic [9:0] h;
      logic [9:0] v;
      logic       active;
      logic [9:0] x;
      logic [9:0] y;
      logic       line_end;
      logic       frame_end;
   } vout_t;

   // Second instance: default horizontal timing, one clock per pixel, short frame.
   localparam int S_VS = 2;
   localparam int S_VB = 3;
   localparam int S_VA = 4;
   localparam int S_VF = 1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic en = 1'b0;

   always #5 clk = ~clk;

   logic       pix_en_d, active_d, line_end_d, frame_end_d;
   logic [9:0] h_count_d, v_count_d, x_d, y_d;
   logic       pix_en_s, active_s, line_end_s, frame_end_s;
   logic [9:0] h_count_s, v_count_s, x_s, y_s;

   vga_timing_counter dut_d (
      .clk (clk), .resetn (resetn), .en (en),
      .pix_en (pix_en_d), .h_count (h_count_d), .v_count (v_count_d),
      .active (active_d), .x (x_d), .y (y_d),
      .line_end (line_end_d), .frame_end (frame_end_d)
   );

   vga_timing_counter #(
      .CLK_DIV (1), .V_SYNC (S_VS), .V_BP (S_VB), .V_ACTIVE (S_VA), .V_FP (S_VF)
   ) dut_s (
      .clk (clk), .resetn (resetn), .en (en),
      .pix_en (pix_en_s), .h_count (h_count_s), .v_count (v_count_s),
      .active (active_s), .x (x_s), .y (y_s),
      .line_end (line_end_s), .frame_end (frame_end_s)
   );

   int     n_tests = 0;
   int     n_fail  = 0;
   longint n       = 0;   // enabled clock edges since reset release

   // Position follows from the number of completed pixel ticks.
   function automatic vout_t model(input int div, input int hs, input int hb, input int ha,
                                   input int hf, input int vs, input int vb, input int va,
                                   input int vf, input longint cnt, input logic e);
      longint ht, vt, ticks, h, v;
      vout_t  m;
      ht    = hs + hb + ha + hf;
      vt    = vs + vb + va + vf;
      ticks = cnt / div;
      h     = ticks % ht;
      v     = (ticks / ht) % vt;
      m.pix_en    = e && ((cnt % div) == div - 1);
      m.h         = 10'(h);
      m.v         = 10'(v);
      m.active    = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
      m.x         = m.active ? 10'(h - (hs + hb)) : 10'd0;
      m.y         = m.active ? 10'(v - (vs + vb)) : 10'd0;
      m.line_end  = m.pix_en && (h == ht - 1);
      m.frame_end = m.line_end && (v == vt - 1);
      return m;
   endfunction

   function automatic vout_t exp_d();
      return model(4, 96, 48, 640, 16, 2, 33, 480, 10, n, en);
   endfunction

   function automatic vout_t exp_s();
      return model(1, 96, 48, 640, 16, S_VS, S_VB, S_VA, S_VF, n, en);
   endfunction

   function automatic vout_t got_d();
      return '{pix_en_d, h_count_d, v_count_d, active_d, x_d, y_d, line_end_d, frame_end_d};
   endfunction

   function automatic vout_t got_s();
      return '{pix_en_s, h_count_s, v_count_s, active_s, x_s, y_s, line_end_s, frame_end_s};
   endfunction

   // Completes the pending clock edge, then drives en mid-cycle and settles.
   task automatic next(input logic e);
      @(posedge clk);
      if (en === 1'b1 && resetn === 1'b1) n++;
      @(negedge clk);
      en = e;
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      en     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (got_d() !== vout_t'(0)) begin
         n_fail++;
         $display("FAIL reset dut_d got=%h exp=0", got_d());
      end
      n_tests++;
      if (got_s() !== vout_t'(0)) begin
         n_fail++;
         $display("FAIL reset dut_s got=%h exp=0", got_s());
      end
   endtask

   task automatic test_first_line();
      int le_cnt = 0;
      resetn = 1'b1;
      en     = 1'b1;
      n      = 0;
      #1;
      for (int i = 0; i <= 3200; i++) begin
         n_tests++;
         if (got_d() !== exp_d()) begin
            n_fail++;
            $display("FAIL first_line dut_d n=%0d got=%h exp=%h", n, got_d(), exp_d());
         end
         n_tests++;
         if (got_s() !== exp_s()) begin
            n_fail++;
            $display("FAIL first_line dut_s n=%0d got=%h exp=%h", n, got_s(), exp_s());
         end
         if (n == 3 || n == 4) begin
            n_tests++;
            if (pix_en_d !== (n == 3) || h_count_d !== 10'(n / 4)) begin
               n_fail++;
               $display("FAIL first_tick n=%0d pix_en=%b h=%0d", n, pix_en_d, h_count_d);
            end
         end
         if (line_end_d === 1'b1) le_cnt++;
         if (i < 3200) next(1'b1);
      end
      n_tests++;
      if (le_cnt != 1 || h_count_d !== 10'd0 || v_count_d !== 10'd1) begin
         n_fail++;
         $display("FAIL line_wrap line_ends=%0d h=%0d v=%0d exp 1,0,1", le_cnt, h_count_d, v_count_d);
      end
   endtask

   task automatic test_en_hold();
      int k = 0;
      int exp_wait;
      while (!(((n / 4) % 800) == 200 && (n % 4) == 1) && k < 4000) begin
         next(1'b1);
         k++;
      end
      n_tests++;
      if (k >= 4000) begin
         n_fail++;
         $display("FAIL en_hold timeout reaching h=200 got h=%0d", h_count_d);
      end
      for (int i = 0; i < 7; i++) begin
         next(1'b0);
         n_tests++;
         if (got_d() !== exp_d() || h_count_d !== 10'd200 || pix_en_d !== 1'b0) begin
            n_fail++;
            $display("FAIL en_hold n=%0d got=%h exp=%h", n, got_d(), exp_d());
         end
      end
      next(1'b1);
      exp_wait = 3 - int'(n % 4);
      k = 0;
      while (pix_en_d !== 1'b1 && k < 8) begin
         next(1'b1);
         k++;
      end
      n_tests++;
      if (k != exp_wait || h_count_d !== 10'd200) begin
         n_fail++;
         $display("FAIL en_resume wait=%0d exp=%0d h=%0d", k, exp_wait, h_count_d);
      end
      next(1'b1);
      n_tests++;
      if (h_count_d !== 10'd201) begin
         n_fail++;
         $display("FAIL en_resume_step h=%0d exp=201", h_count_d);
      end
   endtask

   task automatic test_random_en();
      for (int i = 0; i < 3000; i++) begin
         next($urandom_range(0, 3) != 0);
         n_tests++;
         if (got_d() !== exp_d()) begin
            n_fail++;
            $display("FAIL random_en dut_d n=%0d got=%h exp=%h", n, got_d(), exp_d());
         end
         n_tests++;
         if (got_s() !== exp_s()) begin
            n_fail++;
            $display("FAIL random_en dut_s n=%0d got=%h exp=%h", n, got_s(), exp_s());
         end
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      while (((n / 4) % 800) != 500 && k < 4000) begin
         next(1'b1);
         k++;
      end
      n_tests++;
      if (k >= 4000) begin
         n_fail++;
         $display("FAIL reset_mid timeout reaching h=500 got h=%0d", h_count_d);
      end
      resetn = 1'b0;
      n      = 0;
      #1;
      n_tests++;
      if (got_d() !== vout_t'(0)) begin
         n_fail++;
         $display("FAIL reset_async dut_d got=%h exp=0", got_d());
      end
      n_tests++;
      if (got_s() !== exp_s()) begin
         n_fail++;
         $display("FAIL reset_async dut_s got=%h exp=%h", got_s(), exp_s());
      end
      next(1'b0);
      next(1'b0);
      resetn = 1'b1;
      en     = 1'b1;
      #1;
      for (int i = 0; i < 40; i++) begin
         n_tests++;
         if (got_d() !== exp_d() || (n == 3 && pix_en_d !== 1'b1)) begin
            n_fail++;
            $display("FAIL restart dut_d n=%0d got=%h exp=%h", n, got_d(), exp_d());
         end
         n_tests++;
         if (got_s() !== exp_s()) begin
            n_fail++;
            $display("FAIL restart dut_s n=%0d got=%h exp=%h", n, got_s(), exp_s());
         end
         next(1'b1);
      end
   endtask

   task automatic test_full_frame();
      int fe_cnt = 0;
      int le_cnt = 0;
      int act_cnt = 0;
      resetn = 1'b0;
      next(1'b0);
      next(1'b0);
      resetn = 1'b1;
      en     = 1'b1;
      n      = 0;
      #1;
      for (int i = 0; i <= 8000; i++) begin
         n_tests++;
         if (got_s() !== exp_s()) begin
            n_fail++;
            $display("FAIL frame dut_s n=%0d got=%h exp=%h", n, got_s(), exp_s());
         end
         n_tests++;
         if (got_d() !== exp_d()) begin
            n_fail++;
            $display("FAIL frame dut_d n=%0d got=%h exp=%h", n, got_d(), exp_d());
         end
         if (i == 4143 || i == 4144 || i == 4783 || i == 4784) begin
            n_tests++;
            if (active_s !== (i == 4144 || i == 4783) ||
                x_s !== ((i == 4783) ? 10'd639 : 10'd0)) begin
               n_fail++;
               $display("FAIL window_edge n=%0d active=%b x=%0d", n, active_s, x_s);
            end
         end
         if ((i / 800 == 4 || i / 800 == 9) && i < 8000) begin
            n_tests++;
            if (active_s !== 1'b0) begin
               n_fail++;
               $display("FAIL blank_row n=%0d active=%b exp=0", n, active_s);
            end
         end
         if (i == 7999 || i == 8000) begin
            n_tests++;
            if (h_count_s !== ((i == 7999) ? 10'd799 : 10'd0) ||
                v_count_s !== ((i == 7999) ? 10'd9 : 10'd0) ||
                frame_end_s !== (i == 7999)) begin
               n_fail++;
               $display("FAIL frame_wrap n=%0d h=%0d v=%0d frame_end=%b", n, h_count_s, v_count_s, frame_end_s);
            end
         end
         if (frame_end_s === 1'b1) fe_cnt++;
         if (line_end_s === 1'b1) le_cnt++;
         if (active_s === 1'b1 && pix_en_s === 1'b1) act_cnt++;
         if (i < 8000) next(1'b1);
      end
      n_tests++;
      if (fe_cnt != 1 || le_cnt != 10 || act_cnt != 640 * S_VA) begin
         n_fail++;
         $display("FAIL frame_counts frame_end=%0d line_end=%0d active=%0d exp 1,10,%0d",
                  fe_cnt, le_cnt, act_cnt, 640 * S_VA);
      end
   endtask

   initial begin
      test_reset();
      test_first_line();
      test_en_hold();
      test_random_en();
      test_reset_mid();
      test_full_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
